// File: rtl/button_reader.sv
// rtl/button_reader.sv - push-button synchroniser, debouncer and press/release/long event register
// Optional long-press event enabled by defining BUTTON_READER_LONG_PRESS_EN.
module button_reader #(
   parameter int DEBOUNCE_CYCLES = 480000,
   parameter int LONG_CYCLES     = 48000000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_btn,
   input  logic       i_evt_ack,
   output logic       o_level,
   output logic       o_evt_valid,
   output logic [1:0] o_evt_code,
   output logic       o_overrun
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ST_RELEASED    = 2'd0;
   localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
   localparam logic [1:0] ST_PRESSED     = 2'd2;
   localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

   localparam logic [1:0] CODE_PRESS   = 2'b01;
   localparam logic [1:0] CODE_RELEASE = 2'b10;

   if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_param
      $error("button_reader: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
   end

   logic          sync1;
   logic          sync2;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          post;
   logic [1:0]    post_code;
   logic          press_accept;

   // Two-flop synchroniser on the polarity-corrected pad; reset reads as not pressed.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= i_btn ^ ACTIVE_LOW;
         sync2 <= sync1;
      end
   end

   assign press_accept = (state == ST_PRESS_CHK) && sync2 && (cnt == CNT_LAST);

`ifdef BUTTON_READER_LONG_PRESS_EN
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

   logic [HW-1:0] hold;

   // Saturating at LONG_CYCLES means HOLD_LAST is crossed once per press.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         hold <= '0;
      end else if (press_accept) begin
         hold <= '0;
      end else if ((state == ST_PRESSED || state == ST_RELEASE_CHK) && hold != HOLD_MAX) begin
         hold <= hold + HW'(1);
      end
   end
`endif

   always_comb begin
      post      = 1'b0;
      post_code = 2'b00;
      if (press_accept) begin
         post      = 1'b1;
         post_code = CODE_PRESS;
      end
      if (state == ST_RELEASE_CHK && !sync2 && cnt == CNT_LAST) begin
         post      = 1'b1;
         post_code = CODE_RELEASE;
      end
`ifdef BUTTON_READER_LONG_PRESS_EN
      if (state == ST_PRESSED && hold == HOLD_LAST) begin
         post      = 1'b1;
         post_code = 2'b11;
      end
`endif
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= ST_RELEASED;
         cnt     <= '0;
         o_level <= 1'b0;
      end else begin
         case (state)
            ST_RELEASED: begin
               if (sync2) begin
                  state <= ST_PRESS_CHK;
                  cnt   <= '0;
               end
            end
            ST_PRESS_CHK: begin
               if (!sync2) begin
                  state <= ST_RELEASED;
               end else if (cnt == CNT_LAST) begin
                  state   <= ST_PRESSED;
                  o_level <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_PRESSED: begin
               if (!sync2) begin
                  state <= ST_RELEASE_CHK;
                  cnt   <= '0;
               end
            end
            ST_RELEASE_CHK: begin
               if (sync2) begin
                  state <= ST_PRESSED;
               end else if (cnt == CNT_LAST) begin
                  state   <= ST_RELEASED;
                  o_level <= 1'b0;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= ST_RELEASED;
         endcase
      end
   end

   // A new post always wins over an ack; it only counts as overrun if the old event was unacked.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_evt_valid <= 1'b0;
         o_evt_code  <= 2'b00;
         o_overrun   <= 1'b0;
      end else begin
         o_overrun <= 1'b0;
         if (post) begin
            o_evt_valid <= 1'b1;
            o_evt_code  <= post_code;
            o_overrun   <= o_evt_valid && !i_evt_ack;
         end else if (i_evt_ack && o_evt_valid) begin
            o_evt_valid <= 1'b0;
            o_evt_code  <= 2'b00;
         end
      end
   end

endmodule

// File: tb/tb_button_reader.sv
// tb/tb_button_reader.sv - directed self-checking bench for button_reader (D=4, L=16, active-low pad)
module tb_button_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn;
   logic       ack;
   logic       level;
   logic       evt_valid;
   logic [1:0] evt_code;
   logic       overrun;

   int errors = 0;
   int checks = 0;

   button_reader #(
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES(16),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_btn(btn),
      .i_evt_ack(ack),
      .o_level(level),
      .o_evt_valid(evt_valid),
      .o_evt_code(evt_code),
      .o_overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic l, input logic v,
                          input logic [1:0] c, input logic o);
      chk({tag, ".level"}, {1'b0, level}, {1'b0, l});
      chk({tag, ".valid"}, {1'b0, evt_valid}, {1'b0, v});
      chk({tag, ".code"}, evt_code, c);
      chk({tag, ".overrun"}, {1'b0, overrun}, {1'b0, o});
   endtask

   task automatic ack_one();
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      btn = 1'b1;
      ack = 1'b0;
      #1;
      chk_all("reset", 1'b0, 1'b0, 2'b00, 1'b0);
      tick(2);
      rst = 1'b0;
      tick(2);
      chk_all("idle", 1'b0, 1'b0, 2'b00, 1'b0);

      // 1: clean press, accepted at edge 7, then ack and a clean release
      btn = 1'b0;
      tick(6);
      chk_all("t1.edge6", 1'b0, 1'b0, 2'b00, 1'b0);
      tick(1);
      chk_all("t1.edge7", 1'b1, 1'b1, 2'b01, 1'b0);
      ack_one();
      chk_all("t1.ack", 1'b1, 1'b0, 2'b00, 1'b0);
      ack_one();
      chk_all("t1.ack_idle", 1'b1, 1'b0, 2'b00, 1'b0);
      btn = 1'b1;
      tick(7);
      chk_all("t1.release", 1'b0, 1'b1, 2'b10, 1'b0);
      ack_one();
      tick(2);

      // 2: 3-cycle glitch is rejected
      btn = 1'b0;
      tick(3);
      btn = 1'b1;
      tick(10);
      chk_all("t2.glitch", 1'b0, 1'b0, 2'b00, 1'b0);

      // 3: press, then release with bounce high2/low2/high
      btn = 1'b0;
      tick(7);
      chk_all("t3.press", 1'b1, 1'b1, 2'b01, 1'b0);
      ack_one();
      btn = 1'b1;
      tick(2);
      btn = 1'b0;
      tick(2);
      btn = 1'b1;
      tick(6);
      chk_all("t3.edge6", 1'b1, 1'b0, 2'b00, 1'b0);
      tick(1);
      chk_all("t3.edge7", 1'b0, 1'b1, 2'b10, 1'b0);
      ack_one();
      tick(8);
      chk_all("t3.quiet", 1'b0, 1'b0, 2'b00, 1'b0);

      // 4: long hold with PRESS left unacked
      btn = 1'b0;
      tick(7);
      chk_all("t4.press", 1'b1, 1'b1, 2'b01, 1'b0);
      tick(15);
      chk_all("t4.pre_long", 1'b1, 1'b1, 2'b01, 1'b0);
      tick(1);
`ifdef BUTTON_READER_LONG_PRESS_EN
      chk_all("t4.long", 1'b1, 1'b1, 2'b11, 1'b1);
      tick(1);
      chk_all("t4.after_long", 1'b1, 1'b1, 2'b11, 1'b0);
      tick(6);
      chk_all("t4.held", 1'b1, 1'b1, 2'b11, 1'b0);
`else
      chk_all("t4.no_long", 1'b1, 1'b1, 2'b01, 1'b0);
      tick(1);
      chk_all("t4.after", 1'b1, 1'b1, 2'b01, 1'b0);
      tick(6);
      chk_all("t4.held", 1'b1, 1'b1, 2'b01, 1'b0);
`endif
      ack_one();
      btn = 1'b1;
      tick(7);
      chk_all("t4.release", 1'b0, 1'b1, 2'b10, 1'b0);
      ack_one();
      tick(2);

      // 5a: press and release without ack -> overwrite with one overrun pulse
      btn = 1'b0;
      tick(7);
      chk_all("t5.press", 1'b1, 1'b1, 2'b01, 1'b0);
      btn = 1'b1;
      tick(7);
      chk_all("t5.overrun", 1'b0, 1'b1, 2'b10, 1'b1);
      tick(1);
      chk_all("t5.pulse_end", 1'b0, 1'b1, 2'b10, 1'b0);
      ack_one();
      chk_all("t5.cleared", 1'b0, 1'b0, 2'b00, 1'b0);
      tick(2);

      // 5b: ack in the same cycle as the RELEASE post
      btn = 1'b0;
      tick(7);
      chk_all("t5b.press", 1'b1, 1'b1, 2'b01, 1'b0);
      btn = 1'b1;
      tick(6);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      chk_all("t5b.post_ack", 1'b0, 1'b1, 2'b10, 1'b0);
      tick(2);

      // 6: reset during PRESS_CHK discards pending RELEASE, press re-detected after reset
      btn = 1'b0;
      tick(4);
      chk_all("t6.press_chk", 1'b0, 1'b1, 2'b10, 1'b0);
      rst = 1'b1;
      #1;
      chk_all("t6.in_reset", 1'b0, 1'b0, 2'b00, 1'b0);
      tick(2);
      rst = 1'b0;
      tick(6);
      chk_all("t6.edge6", 1'b0, 1'b0, 2'b00, 1'b0);
      tick(1);
      chk_all("t6.edge7", 1'b1, 1'b1, 2'b01, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
